// File: rtl/instruction_decode.sv
// ID pipeline stage: IF/ID latch, MIPS-subset decode, 32x32 register file with write bypass,
// branch/jump resolution in ID, load-use and branch-operand stall detection, ID/EX latch.
module instruction_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  i_PCNext,
  input  logic [31:0] i_instruction,
  input  logic        i_RegWrite,
  input  logic [4:0]  i_write_reg,
  input  logic [31:0] i_write_data,
  input  logic        i_EX_RegWrite,
  input  logic        i_EX_MemRead,
  input  logic [4:0]  i_EX_write_reg,
  input  logic        i_MEM_RegWrite,
  input  logic [4:0]  i_MEM_write_reg,
  output logic        o_PCWrite,
  output logic        o_PCSrc,
  output logic [7:0]  o_PCBranch,
  output logic [7:0]  o_PCNext,
  output logic [31:0] o_read_data1,
  output logic [31:0] o_read_data2,
  output logic [31:0] o_immediate,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic        o_RegWrite,
  output logic        o_MemRead,
  output logic        o_MemWrite,
  output logic        o_MemtoReg,
  output logic        o_RegDst,
  output logic        o_ALUSrc,
  output logic [1:0]  o_ALUOp
);

  localparam int unsigned PC_W   = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned NREGS  = 32;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  logic [PC_W-1:0]   ifid_pc_q, ifid_pc_d;
  logic [DATA_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [DATA_W-1:0] rf_q [NREGS];

  logic [PC_W-1:0]   idex_pc_q, idex_pc_d;
  logic [DATA_W-1:0] idex_rd1_q, idex_rd1_d;
  logic [DATA_W-1:0] idex_rd2_q, idex_rd2_d;
  logic [DATA_W-1:0] idex_imm_q, idex_imm_d;
  logic [REG_W-1:0]  idex_rs_q, idex_rs_d;
  logic [REG_W-1:0]  idex_rt_q, idex_rt_d;
  logic [REG_W-1:0]  idex_rd_q, idex_rd_d;
  ctrl_t             idex_ctrl_q, idex_ctrl_d;

  logic [5:0]        opcode;
  logic [REG_W-1:0]  rs, rt, rd;
  logic [DATA_W-1:0] imm, rdata1, rdata2;
  ctrl_t             ctrl;
  logic              is_beq, is_bne, is_branch, is_jump;
  logic              load_use, br_hazard, stall, taken, run;
  logic [PC_W-1:0]   target;

  assign opcode = ifid_instr_q[31:26];
  assign rs     = ifid_instr_q[25:21];
  assign rt     = ifid_instr_q[20:16];
  assign rd     = ifid_instr_q[15:11];
  assign imm    = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};

  // Main control decode; unknown opcodes leave every control bit low
  always_comb begin
    ctrl    = '0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_jump = 1'b0;
    case (opcode)
      OP_R:    begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_op = 2'b10; end
      OP_LW:   begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
      end
      OP_SW:   begin ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; end
      OP_ADDI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; end
      OP_BEQ:  begin ctrl.alu_op = 2'b01; is_beq = 1'b1; end
      OP_BNE:  begin ctrl.alu_op = 2'b01; is_bne = 1'b1; end
      OP_J:    is_jump = 1'b1;
      default: ;
    endcase
  end

  assign is_branch = is_beq | is_bne;

  // Register read with same-cycle writeback bypass; r0 is never written so reads 0
  always_comb begin
    rdata1 = rf_q[rs];
    rdata2 = rf_q[rt];
    if (i_RegWrite && (i_write_reg != '0)) begin
      if (i_write_reg == rs) rdata1 = i_write_data;
      if (i_write_reg == rt) rdata2 = i_write_data;
    end
  end

  function automatic logic dest_hit(input logic we, input logic [REG_W-1:0] dest,
                                    input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return we && (dest != '0) && ((dest == a) || (dest == b));
  endfunction

  assign load_use  = dest_hit(i_EX_MemRead, i_EX_write_reg, rs, rt);
  assign br_hazard = is_branch && (dest_hit(i_EX_RegWrite, i_EX_write_reg, rs, rt) ||
                                   dest_hit(i_MEM_RegWrite, i_MEM_write_reg, rs, rt));
  assign stall     = load_use | br_hazard;

  assign taken  = (is_beq & (rdata1 == rdata2)) | (is_bne & (rdata1 != rdata2)) | is_jump;
  assign target = is_jump   ? ifid_instr_q[7:0] :
                  is_branch ? PC_W'(ifid_pc_q + ifid_instr_q[7:0]) : '0;

  // PC control to fetch; reset and a frozen stage both force it quiet
  assign run        = rst & enable;
  assign o_PCWrite  = run & ~stall;
  assign o_PCSrc    = run & taken & ~stall;
  assign o_PCBranch = run ? target : '0;

  // Next-state for IF/ID (stall holds, taken flushes) and ID/EX (stall inserts bubble)
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    if (!stall) begin
      if (taken) begin
        ifid_pc_d    = '0;
        ifid_instr_d = '0;
      end else begin
        ifid_pc_d    = i_PCNext;
        ifid_instr_d = i_instruction;
      end
    end
    idex_pc_d   = ifid_pc_q;
    idex_rd1_d  = rdata1;
    idex_rd2_d  = rdata2;
    idex_imm_d  = imm;
    idex_rs_d   = rs;
    idex_rt_d   = rt;
    idex_rd_d   = rd;
    idex_ctrl_d = stall ? ctrl_t'('0) : ctrl;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
    end else if (enable && i_RegWrite && (i_write_reg != '0)) begin
      rf_q[i_write_reg] <= i_write_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      idex_pc_q    <= '0;
      idex_rd1_q   <= '0;
      idex_rd2_q   <= '0;
      idex_imm_q   <= '0;
      idex_rs_q    <= '0;
      idex_rt_q    <= '0;
      idex_rd_q    <= '0;
      idex_ctrl_q  <= '0;
    end else if (enable) begin
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      idex_pc_q    <= idex_pc_d;
      idex_rd1_q   <= idex_rd1_d;
      idex_rd2_q   <= idex_rd2_d;
      idex_imm_q   <= idex_imm_d;
      idex_rs_q    <= idex_rs_d;
      idex_rt_q    <= idex_rt_d;
      idex_rd_q    <= idex_rd_d;
      idex_ctrl_q  <= idex_ctrl_d;
    end
  end

  assign o_PCNext     = idex_pc_q;
  assign o_read_data1 = idex_rd1_q;
  assign o_read_data2 = idex_rd2_q;
  assign o_immediate  = idex_imm_q;
  assign o_rs         = idex_rs_q;
  assign o_rt         = idex_rt_q;
  assign o_rd         = idex_rd_q;
  assign o_RegWrite   = idex_ctrl_q.reg_write;
  assign o_MemRead    = idex_ctrl_q.mem_read;
  assign o_MemWrite   = idex_ctrl_q.mem_write;
  assign o_MemtoReg   = idex_ctrl_q.mem_to_reg;
  assign o_RegDst     = idex_ctrl_q.reg_dst;
  assign o_ALUSrc     = idex_ctrl_q.alu_src;
  assign o_ALUOp      = idex_ctrl_q.alu_op;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed test-plan steps and a randomized stream, all
// checked against a cycle-level architectural model of the ID stage.
module tb_instruction_decode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable;
  logic [7:0]  i_PCNext;
  logic [31:0] i_instruction;
  logic        i_RegWrite;
  logic [4:0]  i_write_reg;
  logic [31:0] i_write_data;
  logic        i_EX_RegWrite, i_EX_MemRead;
  logic [4:0]  i_EX_write_reg;
  logic        i_MEM_RegWrite;
  logic [4:0]  i_MEM_write_reg;
  logic        o_PCWrite, o_PCSrc;
  logic [7:0]  o_PCBranch, o_PCNext;
  logic [31:0] o_read_data1, o_read_data2, o_immediate;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic        o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg, o_RegDst, o_ALUSrc;
  logic [1:0]  o_ALUOp;

  instruction_decode dut (
    .clk(clk), .rst(rst), .enable(enable),
    .i_PCNext(i_PCNext), .i_instruction(i_instruction),
    .i_RegWrite(i_RegWrite), .i_write_reg(i_write_reg), .i_write_data(i_write_data),
    .i_EX_RegWrite(i_EX_RegWrite), .i_EX_MemRead(i_EX_MemRead), .i_EX_write_reg(i_EX_write_reg),
    .i_MEM_RegWrite(i_MEM_RegWrite), .i_MEM_write_reg(i_MEM_write_reg),
    .o_PCWrite(o_PCWrite), .o_PCSrc(o_PCSrc), .o_PCBranch(o_PCBranch),
    .o_PCNext(o_PCNext), .o_read_data1(o_read_data1), .o_read_data2(o_read_data2),
    .o_immediate(o_immediate), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_RegWrite(o_RegWrite), .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite),
    .o_MemtoReg(o_MemtoReg), .o_RegDst(o_RegDst), .o_ALUSrc(o_ALUSrc), .o_ALUOp(o_ALUOp)
  );

  int checks = 0;
  int errors = 0;

  // Architectural state of the model: register file, IF/ID contents, expected ID/EX contents
  logic [31:0] m_rf [32];
  logic [7:0]  m_pc;
  logic [31:0] m_ins;
  logic [7:0]  e_pc;
  logic [31:0] e_rd1, e_rd2, e_imm;
  logic [4:0]  e_rs, e_rt, e_rd;
  logic [7:0]  e_ctrl;
  // Pending update computed before the edge
  logic        n_run, n_we;
  logic [4:0]  n_wr;
  logic [31:0] n_wd, n_ins, n_rd1, n_rd2, n_imm;
  logic [7:0]  n_pc, n_epc, n_ctrl;
  logic [4:0]  n_rs, n_rt, n_rd;
  logic        x_pcwrite, x_pcsrc;
  logic [7:0]  x_pcb;
  logic        obs_pcwrite, obs_pcsrc;
  logic [7:0]  obs_pcb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Control word {RegWrite,MemRead,MemWrite,MemtoReg,RegDst,ALUSrc,ALUOp}
  function automatic logic [7:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'b000000: return 8'b1000_1010;
      6'b100011: return 8'b1101_0100;
      6'b101011: return 8'b0010_0100;
      6'b001000: return 8'b1000_0100;
      6'b000100, 6'b000101: return 8'b0000_0001;
      default:   return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] reg_value(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (i_RegWrite && i_write_reg == r) return i_write_data;
    return m_rf[r];
  endfunction

  function automatic logic writes_src(input logic we, input logic [4:0] d,
                                      input logic [4:0] a, input logic [4:0] b);
    return we && d != 5'd0 && (d == a || d == b);
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'b000000, s, t, d, 5'd0, 6'h20};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_pc = 8'd0; m_ins = 32'd0;
    e_pc = 8'd0; e_rd1 = 32'd0; e_rd2 = 32'd0; e_imm = 32'd0;
    e_rs = 5'd0; e_rt = 5'd0; e_rd = 5'd0; e_ctrl = 8'd0;
  endtask

  task automatic model_eval();
    logic [5:0]  op;
    logic [4:0]  s, t;
    logic [31:0] a, b;
    logic        br, tk, st;
    logic [7:0]  tgt;
    op = m_ins[31:26]; s = m_ins[25:21]; t = m_ins[20:16];
    a = reg_value(s); b = reg_value(t);
    br = (op == 6'd4) || (op == 6'd5);
    tk = (op == 6'd4 && a == b) || (op == 6'd5 && a != b) || (op == 6'd2);
    if (op == 6'd2) tgt = m_ins[7:0];
    else if (br)    tgt = 8'((int'(m_pc) + int'(m_ins[7:0])) % 256);
    else            tgt = 8'd0;
    st = writes_src(i_EX_MemRead, i_EX_write_reg, s, t) ||
         (br && (writes_src(i_EX_RegWrite, i_EX_write_reg, s, t) ||
                 writes_src(i_MEM_RegWrite, i_MEM_write_reg, s, t)));
    n_run = rst && enable;
    x_pcwrite = n_run && !st;
    x_pcsrc   = n_run && tk && !st;
    x_pcb     = n_run ? tgt : 8'd0;
    n_epc = m_pc; n_rd1 = a; n_rd2 = b;
    n_imm = {{16{m_ins[15]}}, m_ins[15:0]};
    n_rs = s; n_rt = t; n_rd = m_ins[15:11];
    n_ctrl = st ? 8'd0 : ctrl_of(op);
    if (st)      begin n_pc = m_pc; n_ins = m_ins; end
    else if (tk) begin n_pc = 8'd0; n_ins = 32'd0; end
    else         begin n_pc = i_PCNext; n_ins = i_instruction; end
    n_we = i_RegWrite && i_write_reg != 5'd0;
    n_wr = i_write_reg; n_wd = i_write_data;
  endtask

  task automatic model_commit();
    if (!n_run) return;
    if (n_we) m_rf[n_wr] = n_wd;
    m_pc = n_pc; m_ins = n_ins;
    e_pc = n_epc; e_rd1 = n_rd1; e_rd2 = n_rd2; e_imm = n_imm;
    e_rs = n_rs; e_rt = n_rt; e_rd = n_rd; e_ctrl = n_ctrl;
  endtask

  // One clock: check PC-control mid-cycle, clock, then check the ID/EX latch
  task automatic cycle(input string tag);
    @(negedge clk);
    model_eval();
    obs_pcwrite = o_PCWrite; obs_pcsrc = o_PCSrc; obs_pcb = o_PCBranch;
    chk({tag, ".pcwrite"}, 32'(o_PCWrite), 32'(x_pcwrite));
    chk({tag, ".pcsrc"}, 32'(o_PCSrc), 32'(x_pcsrc));
    chk({tag, ".pcbranch"}, 32'(o_PCBranch), 32'(x_pcb));
    @(posedge clk); #1;
    model_commit();
    chk({tag, ".pcnext"}, 32'(o_PCNext), 32'(e_pc));
    chk({tag, ".rd1"}, o_read_data1, e_rd1);
    chk({tag, ".rd2"}, o_read_data2, e_rd2);
    chk({tag, ".imm"}, o_immediate, e_imm);
    chk({tag, ".regs"}, 32'({o_rs, o_rt, o_rd}), 32'({e_rs, e_rt, e_rd}));
    chk({tag, ".ctrl"}, 32'({o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg, o_RegDst, o_ALUSrc, o_ALUOp}),
        32'(e_ctrl));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pcctl"}, 32'({o_PCWrite, o_PCSrc, o_PCBranch}), 32'd0);
    chk({tag, ".idex_data"}, o_read_data1 | o_read_data2 | o_immediate, 32'd0);
    chk({tag, ".idex_misc"}, 32'({o_PCNext, o_rs, o_rt, o_rd, o_RegWrite, o_MemRead, o_MemWrite,
                                  o_MemtoReg, o_RegDst, o_ALUSrc, o_ALUOp}), 32'd0);
  endtask

  task automatic idle();
    enable = 1'b1; i_PCNext = 8'd0; i_instruction = 32'd0;
    i_RegWrite = 1'b0; i_write_reg = 5'd0; i_write_data = 32'd0;
    i_EX_RegWrite = 1'b0; i_EX_MemRead = 1'b0; i_EX_write_reg = 5'd0;
    i_MEM_RegWrite = 1'b0; i_MEM_write_reg = 5'd0;
  endtask

  task automatic randomize_inputs();
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h04, 6'h05, 6'h02, 6'h3f};
    enable = ($urandom_range(0, 9) != 0);
    i_PCNext = 8'($urandom);
    i_instruction = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     16'($urandom)};
    i_RegWrite = 1'($urandom);
    i_write_reg = 5'($urandom_range(0, 7));
    i_write_data = 32'($urandom_range(0, 3));
    i_EX_RegWrite = ($urandom_range(0, 3) == 0);
    i_EX_MemRead = ($urandom_range(0, 4) == 0);
    i_EX_write_reg = 5'($urandom_range(0, 7));
    i_MEM_RegWrite = ($urandom_range(0, 3) == 0);
    i_MEM_write_reg = 5'($urandom_range(0, 7));
  endtask

  initial begin
    // Reset with random inputs: everything quiet, nothing captured across an edge
    rst = 1'b0;
    randomize_inputs();
    enable = 1'b1; i_RegWrite = 1'b1; i_write_reg = 5'd3;
    model_reset();
    #1;
    chk_all_zero("reset_async");
    @(posedge clk); #1;
    chk_all_zero("reset_edge");
    rst = 1'b1;
    idle();
    #1;
    chk("reset_release.pcwrite", 32'(o_PCWrite), 32'd1);

    // Writeback r5 then ADDI r6,r5,7 reads the written value
    idle(); i_RegWrite = 1'b1; i_write_reg = 5'd5; i_write_data = 32'h1234;
    i_instruction = enc_i(6'h08, 5'd5, 5'd6, 16'd7); i_PCNext = 8'd1;
    cycle("wb_r5");
    idle();
    cycle("addi");
    chk("addi.rd1", o_read_data1, 32'h1234);
    chk("addi.imm", o_immediate, 32'd7);
    chk("addi.alusrc_regwrite", 32'({o_ALUSrc, o_RegWrite}), 32'b11);

    // Write to r0 is ignored
    idle(); i_RegWrite = 1'b1; i_write_reg = 5'd0; i_write_data = 32'hFFFF_FFFF;
    i_instruction = enc_r(5'd0, 5'd0, 5'd3);
    cycle("wb_r0");
    idle();
    cycle("read_r0");
    chk("read_r0.rd1", o_read_data1, 32'd0);

    // Load-use: LW r2 in EX while ADD r3,r2,r1 sits in IF/ID
    idle(); i_instruction = enc_r(5'd2, 5'd1, 5'd3); i_PCNext = 8'd5;
    cycle("lu_fetch");
    idle(); i_EX_MemRead = 1'b1; i_EX_RegWrite = 1'b1; i_EX_write_reg = 5'd2;
    i_instruction = enc_i(6'h08, 5'd1, 5'd1, 16'd1); i_PCNext = 8'd6;
    cycle("lu_stall");
    chk("lu_stall.pcwrite", 32'(obs_pcwrite), 32'd0);
    chk("lu_stall.regwrite", 32'(o_RegWrite), 32'd0);
    idle(); i_MEM_RegWrite = 1'b1; i_MEM_write_reg = 5'd2;
    i_instruction = enc_i(6'h08, 5'd1, 5'd1, 16'd1); i_PCNext = 8'd6;
    cycle("lu_issue");
    chk("lu_issue.pcwrite", 32'(obs_pcwrite), 32'd1);
    chk("lu_issue.add", 32'({o_RegWrite, o_RegDst, o_rd}), 32'({1'b1, 1'b1, 5'd3}));

    // BEQ r1,r1,+3 at PCNext 10 is taken to 13 and flushes the fetched slot
    idle(); i_instruction = enc_i(6'h04, 5'd1, 5'd1, 16'd3); i_PCNext = 8'd10;
    cycle("beq_fetch");
    idle(); i_instruction = enc_r(5'd1, 5'd2, 5'd4); i_PCNext = 8'd11;
    cycle("beq");
    chk("beq.pcsrc", 32'(obs_pcsrc), 32'd1);
    chk("beq.pcbranch", 32'(obs_pcb), 32'd13);
    idle();
    cycle("beq_flush");
    chk("beq_flush.pcnext", 32'(o_PCNext), 32'd0);

    // BNE with equal registers is not taken
    idle(); i_instruction = enc_i(6'h05, 5'd1, 5'd1, 16'd3); i_PCNext = 8'd20;
    cycle("bne_fetch");
    idle();
    cycle("bne");
    chk("bne.pcsrc", 32'(obs_pcsrc), 32'd0);

    // Target wraps modulo 256; jump target is the low instruction byte
    idle(); i_instruction = enc_i(6'h04, 5'd0, 5'd0, 16'd10); i_PCNext = 8'd250;
    cycle("wrap_fetch");
    idle(); i_instruction = {6'b000010, 26'h3C};
    cycle("wrap");
    chk("wrap.pcbranch", 32'(obs_pcb), 32'd4);
    idle();
    cycle("j_flush");
    idle(); i_instruction = {6'b000010, 26'h3C};
    cycle("j_fetch");
    idle();
    cycle("j");
    chk("j.pcbranch", 32'(obs_pcb), 32'h3C);
    chk("j.pcsrc", 32'(obs_pcsrc), 32'd1);

    // BEQ r4,r7 with r4 producer in EX, then MEM, then resolved through writeback bypass
    idle(); i_RegWrite = 1'b1; i_write_reg = 5'd7; i_write_data = 32'h55;
    i_instruction = enc_i(6'h04, 5'd4, 5'd7, 16'd2); i_PCNext = 8'd30;
    cycle("br_fetch");
    idle(); i_EX_RegWrite = 1'b1; i_EX_write_reg = 5'd4;
    cycle("br_stall_ex");
    chk("br_stall_ex.pcwrite", 32'(obs_pcwrite), 32'd0);
    idle(); i_MEM_RegWrite = 1'b1; i_MEM_write_reg = 5'd4;
    cycle("br_stall_mem");
    chk("br_stall_mem.pcwrite", 32'(obs_pcwrite), 32'd0);
    idle(); i_RegWrite = 1'b1; i_write_reg = 5'd4; i_write_data = 32'h55;
    cycle("br_resolve");
    chk("br_resolve.pcsrc", 32'({obs_pcwrite, obs_pcsrc}), 32'b11);
    chk("br_resolve.pcbranch", 32'(obs_pcb), 32'd32);

    // Frozen stage: no PC control, no state change
    idle(); enable = 1'b0; i_RegWrite = 1'b1; i_write_reg = 5'd9; i_write_data = 32'hDEAD;
    i_instruction = enc_r(5'd9, 5'd9, 5'd9);
    cycle("frozen");
    chk("frozen.pcwrite", 32'(obs_pcwrite), 32'd0);

    // Randomized stream against the model
    for (int k = 0; k < 400; k++) begin
      randomize_inputs();
      cycle("rand");
    end

    // Reset mid-stream, then resume from a NOP in IF/ID
    rst = 1'b0;
    #2;
    chk_all_zero("reset_mid");
    model_reset();
    rst = 1'b1;
    for (int k = 0; k < 100; k++) begin
      randomize_inputs();
      cycle("rand2");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
